// File: rtl/ppi_bus_master_if.sv
// Host-side request/response and 8255-side bus signals for the PPI bus initiator.
// master = the initiator itself; slave = whoever drives requests and models the 8255.
interface ppi_bus_master_if;
  // host side
  logic       req;
  logic       wr;
  logic [1:0] addr;
  logic [7:0] wdata;
  logic       ready;
  logic       done;
  logic [7:0] rdata;
  // 8255 side
  logic       nCS;
  logic [1:0] A;
  logic       nRD;
  logic       nWR;
  logic [7:0] DataOut;
  logic       DataOE;
  logic [7:0] DataIn;

  modport master (
    input  req, wr, addr, wdata, DataIn,
    output ready, done, rdata, nCS, A, nRD, nWR, DataOut, DataOE
  );

  modport slave (
    output req, wr, addr, wdata, DataIn,
    input  ready, done, rdata, nCS, A, nRD, nWR, DataOut, DataOE
  );
endinterface

// File: rtl/ppi_bus_master.sv
// Turns single-cycle host requests into timed 8255 bus cycles (setup / strobe / hold),
// with an optional control-word write issued automatically after reset.
module ppi_bus_master #(
  parameter int unsigned SETUP     = 1,
  parameter int unsigned STROBE    = 2,
  parameter int unsigned HOLD      = 1,
  parameter bit          INIT_EN   = 1'b1,
  parameter logic [7:0]  INIT_WORD = 8'h80
) (
  input  logic              clk,
  input  logic              nReset,
  ppi_bus_master_if.master  bus
);

  // Phase counters load N-1 so that N=1 gives a single cycle.
  localparam logic [3:0] SET_LD = 4'(SETUP - 1);
  localparam logic [3:0] STB_LD = 4'(STROBE - 1);
  localparam logic [3:0] HLD_LD = 4'(HOLD - 1);

  typedef enum logic [2:0] {
    S_BOOT,
    S_IDLE,
    S_SETUP,
    S_STROBE,
    S_HOLD
  } state_e;

  typedef struct packed {
    logic       wr;
    logic [1:0] addr;
    logic [7:0] wdata;
  } req_t;

  state_e     state_q, state_d;
  logic [3:0] cnt_q,   cnt_d;
  logic       init_q,  init_d;
  logic       wr_q,    wr_d;
  logic       ncs_q,   ncs_d;
  logic [1:0] a_q,     a_d;
  logic       nrd_q,   nrd_d;
  logic       nwr_q,   nwr_d;
  logic [7:0] dout_q,  dout_d;
  logic       doe_q,   doe_d;
  logic       ready_q, ready_d;
  logic       done_q,  done_d;
  logic [7:0] rdata_q, rdata_d;

  logic       start;
  req_t       nreq;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    init_d  = init_q;
    wr_d    = wr_q;
    ncs_d   = ncs_q;
    a_d     = a_q;
    nrd_d   = nrd_q;
    nwr_d   = nwr_q;
    dout_d  = dout_q;
    doe_d   = doe_q;
    ready_d = ready_q;
    done_d  = 1'b0;
    rdata_d = rdata_q;
    start   = 1'b0;
    nreq    = '0;

    case (state_q)
      S_BOOT: begin
        if (INIT_EN) begin
          start  = 1'b1;
          nreq   = '{wr: 1'b1, addr: 2'b11, wdata: INIT_WORD};
          init_d = 1'b1;
        end else begin
          state_d = S_IDLE;
          ready_d = 1'b1;
        end
      end

      S_IDLE: begin
        if (bus.req) begin
          start = 1'b1;
          nreq  = '{wr: bus.wr, addr: bus.addr, wdata: bus.wdata};
        end
      end

      S_SETUP: begin
        if (cnt_q == 4'd0) begin
          state_d = S_STROBE;
          cnt_d   = STB_LD;
          nrd_d   = wr_q;
          nwr_d   = ~wr_q;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end

      S_STROBE: begin
        if (cnt_q == 4'd0) begin
          state_d = S_HOLD;
          cnt_d   = HLD_LD;
          nrd_d   = 1'b1;
          nwr_d   = 1'b1;
          // capture on the same edge that releases nRD
          if (!wr_q) rdata_d = bus.DataIn;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end

      S_HOLD: begin
        if (cnt_q == 4'd0) begin
          state_d = S_IDLE;
          ncs_d   = 1'b1;
          doe_d   = 1'b0;
          ready_d = 1'b1;
          done_d  = ~init_q;
          init_d  = 1'b0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end

      default: state_d = S_IDLE;
    endcase

    // Accepting a request (host or init) opens the setup phase on this edge.
    if (start) begin
      state_d = S_SETUP;
      cnt_d   = SET_LD;
      wr_d    = nreq.wr;
      ncs_d   = 1'b0;
      a_d     = nreq.addr;
      doe_d   = nreq.wr;
      ready_d = 1'b0;
      if (nreq.wr) dout_d = nreq.wdata;
    end
  end

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      state_q <= S_BOOT;
      cnt_q   <= 4'd0;
      init_q  <= 1'b0;
      wr_q    <= 1'b0;
      ncs_q   <= 1'b1;
      a_q     <= 2'b00;
      nrd_q   <= 1'b1;
      nwr_q   <= 1'b1;
      dout_q  <= 8'h00;
      doe_q   <= 1'b0;
      ready_q <= 1'b0;
      done_q  <= 1'b0;
      rdata_q <= 8'h00;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      init_q  <= init_d;
      wr_q    <= wr_d;
      ncs_q   <= ncs_d;
      a_q     <= a_d;
      nrd_q   <= nrd_d;
      nwr_q   <= nwr_d;
      dout_q  <= dout_d;
      doe_q   <= doe_d;
      ready_q <= ready_d;
      done_q  <= done_d;
      rdata_q <= rdata_d;
    end
  end

  assign bus.nCS     = ncs_q;
  assign bus.A       = a_q;
  assign bus.nRD     = nrd_q;
  assign bus.nWR     = nwr_q;
  assign bus.DataOut = dout_q;
  assign bus.DataOE  = doe_q;
  assign bus.ready   = ready_q;
  assign bus.done    = done_q;
  assign bus.rdata   = rdata_q;

endmodule
